// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: counter width and common
// system-clock division ratios.
package clk_div_pkg;

   localparam int DEF_CNT_W  = 28;
   localparam int SYS_CLK_HZ = 100_000_000;
   localparam int DIV_4HZ    = 25_000_000;
   localparam int DIV_1KHZ   = 100_000;

   // Returns 0 (channel off) for non-positive rates.
   function automatic int period_for_hz(input int hz);
      return (hz <= 0) ? 0 : SYS_CLK_HZ / hz;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: 1-based up-counter, active and staged period/high,
// registered divided output and wrap tick.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int DEFAULT_PERIOD = DIV_4HZ,
   parameter int DEFAULT_HIGH   = DIV_4HZ / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             ch_en,
   input  logic             wr,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] count, period, high, pend_period, pend_high;
   logic             pend_valid;
   logic [CNT_W-1:0] count_nxt, period_nxt, high_nxt;
   logic             wrap, restart, adopt;

   // High for the last H counts of the period; the low-phase length is formed
   // one bit wider so it can never wrap around.
   function automatic logic phase_high(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] p,
                                       input logic [CNT_W-1:0] h);
      logic [CNT_W:0] low_len;
      low_len = {1'b0, p} - {1'b0, h};
      if (p == '0 || h == '0) return 1'b0;
      else if (h >= p)        return 1'b1;
      else                    return {1'b0, cnt} > low_len;
   endfunction

   always_comb begin
      wrap       = (period != '0) && (count >= period);
      restart    = !ch_en || (period == '0) || wrap;
      adopt      = en && pend_valid && restart;
      period_nxt = adopt ? pend_period : period;
      high_nxt   = adopt ? pend_high : high;
      count_nxt  = count;
      if (en) count_nxt = restart ? CNT_W'(1) : count + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= CNT_W'(1);
         period      <= CNT_W'(DEFAULT_PERIOD);
         high        <= CNT_W'(DEFAULT_HIGH);
         pend_period <= CNT_W'(DEFAULT_PERIOD);
         pend_high   <= CNT_W'(DEFAULT_HIGH);
         pend_valid  <= 1'b0;
         clk_out     <= 1'b0;
         tick        <= 1'b0;
      end else begin
         if (wr) begin
            pend_period <= cfg_period;
            pend_high   <= cfg_high;
         end
         // A write landing on the adoption edge stays pending for the next wrap.
         pend_valid <= wr || (pend_valid && !adopt);
         count      <= count_nxt;
         period     <= period_nxt;
         high       <= high_nxt;
         tick       <= en && ch_en && wrap;
         if (en) clk_out <= ch_en && phase_high(count_nxt, period_nxt, high_nxt);
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers; the top level only
// decodes config writes into per-channel strobes.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int DEFAULT_PERIOD = DIV_4HZ,
   parameter int DEFAULT_HIGH   = DIV_4HZ / 2,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   // Channel indices at or above NUM_CH match no strobe, so such writes drop.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr;
      assign wr = cfg_we && (cfg_ch == CH_W'(i));

      clk_div_channel #(
         .CNT_W          (CNT_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD),
         .DEFAULT_HIGH   (DEFAULT_HIGH)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en),
         .ch_en      (ch_en[i]),
         .wr         (wr),
         .cfg_period (cfg_period),
         .cfg_high   (cfg_high),
         .clk_out    (clk_out[i]),
         .tick       (tick[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a per-channel reference model predicts
// clk_out/tick for every edge; a monitor compares what the DUT presents.
module tb_clk_div_bank;

   localparam int NCH = 2;
   localparam int DP  = 10;
   localparam int DH  = 5;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic [NCH-1:0] ch_en = '0;
   logic           cfg_we = 1'b0;
   logic [0:0]     cfg_ch = '0;
   logic [7:0]     cfg_period = '0;
   logic [7:0]     cfg_high = '0;
   logic [NCH-1:0] clk_out, tick;

   clk_div_bank #(
      .NUM_CH(NCH), .CNT_W(8), .DEFAULT_PERIOD(DP), .DEFAULT_HIGH(DH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
      .clk_out(clk_out), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0] out;
      logic [NCH-1:0] tck;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: position within the period, active and staged settings.
   int m_pos[NCH], m_p[NCH], m_h[NCH], m_pp[NCH], m_hp[NCH];
   bit m_pv[NCH], m_out[NCH], m_tick[NCH];

   function automatic bit level(input int pos, input int p, input int h);
      return (p > 0) && (h > 0) && (pos > p - h);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_pos[i] = 1; m_p[i] = DP; m_h[i] = DH; m_pp[i] = DP; m_hp[i] = DH;
         m_pv[i] = 0; m_out[i] = 0; m_tick[i] = 0;
      end
   endfunction

   function automatic void model_step(input bit e, input logic [NCH-1:0] ce,
                                      input bit we, input int ch, input int per,
                                      input int hi);
      for (int i = 0; i < NCH; i++) begin
         bit at_end;
         at_end = (m_p[i] > 0) && (m_pos[i] >= m_p[i]);
         m_tick[i] = 0;
         if (e) begin
            if (!ce[i] || m_p[i] == 0 || at_end) begin
               if (m_pv[i]) begin
                  m_p[i] = m_pp[i]; m_h[i] = m_hp[i]; m_pv[i] = 0;
               end
               m_pos[i] = 1;
               m_tick[i] = ce[i] && at_end;
            end else begin
               m_pos[i] = m_pos[i] + 1;
            end
            m_out[i] = ce[i] && level(m_pos[i], m_p[i], m_h[i]);
         end
         if (we && ch == i) begin
            m_pp[i] = per; m_hp[i] = hi; m_pv[i] = 1;
         end
      end
   endfunction

   task automatic push_expected();
      exp_t x;
      for (int i = 0; i < NCH; i++) begin
         x.out[i] = m_out[i];
         x.tck[i] = m_tick[i];
      end
      x.cyc = cyc;
      sb.push_back(x);
   endtask

   task automatic drive(input bit e, input logic [NCH-1:0] ce, input bit we = 0,
                        input int ch = 0, input int per = 0, input int hi = 0);
      en = e; ch_en = ce; cfg_we = we; cfg_ch = 1'(ch);
      cfg_period = 8'(per); cfg_high = 8'(hi);
      cyc++;
      if (!rst_n) model_reset();
      else        model_step(e, ce, we, ch, per, hi);
      push_expected();
   endtask

   task automatic cycle(input bit e, input logic [NCH-1:0] ce, input bit we = 0,
                        input int ch = 0, input int per = 0, input int hi = 0);
      @(negedge clk);
      drive(e, ce, we, ch, per, hi);
   endtask

   task automatic run(input int n);
      repeat (n) cycle(1, 2'b11);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (clk_out !== '0 || tick !== '0) begin
         errors++;
         $display("FAIL %s: clk_out=%b tick=%b, required 00/00", name, clk_out, tick);
      end
   endtask

   // Reset asserted between clock edges; outputs must clear without an edge.
   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      push_expected();
      repeat (2) cycle(1, 2'b11);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 2'b11);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks += 2;
            if (clk_out !== x.out) begin
               errors++;
               $display("FAIL clk_out cycle %0d: got %b required %b", x.cyc, clk_out, x.out);
            end
            if (tick !== x.tck) begin
               errors++;
               $display("FAIL tick cycle %0d: got %b required %b", x.cyc, tick, x.tck);
            end
         end
      end
   end

   initial begin : stimulus
      int budget;
      model_reset();
      #1 check_zero("reset_state");
      repeat (3) cycle(0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 2'b11);

      run(25);
      cycle(1, 2'b11, 1, 1, 4, 1);
      run(30);
      cycle(1, 2'b11, 1, 0, 6, 0);
      run(20);
      cycle(1, 2'b11, 1, 0, 6, 6);
      run(20);
      cycle(1, 2'b11, 1, 0, 0, 2);
      run(15);
      cycle(1, 2'b11, 1, 0, 3, 1);
      run(12);
      cycle(1, 2'b11, 1, 0, 10, 5);
      run(17);
      repeat (7) cycle(0, 2'b11);
      run(15);
      cycle(1, 2'b11, 1, 1, 2, 1);
      repeat (4) cycle(1, 2'b01);
      run(8);
      cycle(1, 2'b11, 1, 0, 3, 2);
      run(2);
      async_reset();
      run(25);

      for (int k = 0; k < 800; k++) begin
         logic [NCH-1:0] ce;
         ce = 2'b11;
         if ($urandom_range(0, 29) == 0) ce = 2'($urandom);
         cycle($urandom_range(0, 19) != 0, ce, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 14));
      end

      budget = 10;
      while (sb.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
